// File: rtl/icache_sa.sv
// -----------------------------------------------------------------------------
// icache_sa -- N-way set-associative instruction cache with multi-word refill.
//
// Gives a zero-latency hit lookup for the fetch PC. On a miss, a refill
// engine fetches the whole line one word at a time over a request/valid-strobe
// memory handshake. A flush walks all sets, one per cycle, and clears the
// valid bits; this is used for fence.i.
//
// Parameters:
//   WAYS        ways per set (power of two, 1..8)
//   SETS        number of sets (power of two, >= 2)
//   LINE_WORDS  32-bit words per line (power of two, >= 1)
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   i_addr        fetch address (word aligned)
//   i_req         fetch request this cycle
//   o_hit         i_addr is resident and o_rdata is valid (only in IDLE)
//   o_rdata       instruction word at i_addr (don't-care when o_hit=0)
//   o_busy        a refill or a flush is in progress
//   i_flush       single-cycle pulse that invalidates every line
//   o_mem_req     refill word request (registered)
//   o_mem_addr    refill word address (registered)
//   i_mem_data    refill word
//   i_mem_vd      i_mem_data is valid for the current o_mem_addr
//   o_hit_cnt     hit counter (tied to 0 unless ICACHE_STATS_EN)
//   o_miss_cnt    miss counter (tied to 0 unless ICACHE_STATS_EN)
//
// Build option:
//   ICACHE_STATS_EN  when defined, adds the 32-bit hit and miss counters.
//                    Both are cleared by rst or i_flush and wrap at 2^32.
// -----------------------------------------------------------------------------
module icache_sa #(
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr,
  input  logic        i_req,
  output logic        o_hit,
  output logic [31:0] o_rdata,
  output logic        o_busy,
  input  logic        i_flush,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic [31:0] i_mem_data,
  input  logic        i_mem_vd,
  output logic [31:0] o_hit_cnt,
  output logic [31:0] o_miss_cnt
);

  localparam int OFS    = $clog2(LINE_WORDS) + 2;
  localparam int IDX    = $clog2(SETS);
  localparam int TAG    = 32 - IDX - OFS;
  localparam int WSEL_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [WSEL_W-1:0] LAST_WORD = WSEL_W'(LINE_WORDS - 1);
  localparam logic [IDX-1:0]    LAST_SET  = IDX'(SETS - 1);
  localparam logic [31:0]       LINE_MASK = 32'(LINE_WORDS * 4 - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REFILL,
    S_FLUSH
  } state_t;

  // Storage. Only the valid bits and round-robin pointers are reset; tag and
  // data contents are meaningless while the matching valid bit is clear.
  logic [WAYS-1:0]  r_valid [SETS];
  logic [TAG-1:0]   r_tag   [SETS][WAYS];
  logic [31:0]      r_data  [SETS][WAYS][LINE_WORDS];
  logic [WAY_W-1:0] r_rr    [SETS];

  // Control state
  state_t            r_state;
  state_t            w_next;
  logic              r_mem_req;
  logic [31:0]       r_mem_addr;
  logic [WSEL_W-1:0] r_cnt;
  logic              r_flush_pend;
  logic [IDX-1:0]    r_fidx;
  logic [WAY_W-1:0]  r_victim;
  logic              r_vic_rr;
  logic [IDX-1:0]    r_lidx;
  logic [TAG-1:0]    r_ltag;

  // Address decode of the lookup address
  logic [IDX-1:0]    w_idx;
  logic [TAG-1:0]    w_tag;
  logic [WSEL_W-1:0] w_wsel;

  logic              w_hit_any;
  logic [31:0]       w_rdata;
  logic [WAY_W-1:0]  w_victim;
  logic              w_vic_rr;
  logic              w_start_refill;
  logic              w_start_flush;
  logic              w_ack;
  logic              w_last_ack;

  assign w_idx  = IDX'(i_addr >> OFS);
  assign w_tag  = TAG'(i_addr >> (IDX + OFS));
  // Masking makes the word select collapse to 0 for single-word lines.
  assign w_wsel = WSEL_W'(i_addr >> 2) & LAST_WORD;

  // Lookup stage: tag compare across all ways of the indexed set
  always_comb begin
    w_hit_any = 1'b0;
    w_rdata   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit_any = 1'b1;
        w_rdata   = r_data[w_idx][w][w_wsel];
      end
    end
  end

  // Victim choice: the lowest-numbered invalid way wins. Scanning downward
  // lets the lowest index overwrite earlier candidates. Only when every way
  // is valid does the round-robin pointer decide.
  always_comb begin
    w_victim = r_rr[w_idx];
    w_vic_rr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_idx][w]) begin
        w_victim = WAY_W'(w);
        w_vic_rr = 1'b0;
      end
    end
  end

  assign w_ack      = (r_state == S_REFILL) && i_mem_vd;
  assign w_last_ack = w_ack && (r_cnt == LAST_WORD);

  // Next-state logic
  always_comb begin
    w_next         = r_state;
    w_start_refill = 1'b0;
    w_start_flush  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Flush takes priority over a miss in the same cycle.
        if (i_flush) begin
          w_next        = S_FLUSH;
          w_start_flush = 1'b1;
        end else if (i_req && !w_hit_any) begin
          w_next         = S_REFILL;
          w_start_refill = 1'b1;
        end
      end
      S_REFILL: begin
        // The line always completes; a flush seen meanwhile runs afterwards.
        if (w_last_ack) begin
          if (r_flush_pend || i_flush) begin
            w_next        = S_FLUSH;
            w_start_flush = 1'b1;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      S_FLUSH: begin
        if (r_fidx == LAST_SET) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Refill / flush sequencing registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
      r_fidx       <= '0;
      r_victim     <= '0;
      r_vic_rr     <= 1'b0;
      r_lidx       <= '0;
    end else begin
      if (w_start_refill) begin
        r_mem_req  <= 1'b1;
        r_mem_addr <= i_addr & ~LINE_MASK;
        r_cnt      <= '0;
        r_victim   <= w_victim;
        r_vic_rr   <= w_vic_rr;
        r_lidx     <= w_idx;
      end else if (w_ack) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == LAST_WORD) begin
          r_mem_req <= 1'b0;
        end else begin
          r_mem_addr <= r_mem_addr + 32'd4;
        end
      end

      if (w_start_flush) begin
        r_flush_pend <= 1'b0;
      end else if ((r_state == S_REFILL) && i_flush) begin
        r_flush_pend <= 1'b1;
      end

      if (w_start_flush) begin
        r_fidx <= '0;
      end else if (r_state == S_FLUSH) begin
        r_fidx <= r_fidx + 1'b1;
      end
    end
  end

  // The tag of the line being filled is captured without reset.
  always_ff @(posedge clk) begin
    if (w_start_refill) begin
      r_ltag <= w_tag;
    end
  end

  // Valid bits: a line becomes valid only after its final word arrives, so
  // an interrupted refill never exposes a partial line.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
      end
    end else if (r_state == S_FLUSH) begin
      r_valid[r_fidx] <= '0;
    end else if (w_last_ack) begin
      r_valid[r_lidx][r_victim] <= 1'b1;
    end
  end

  // Round-robin pointers advance only when they picked the victim.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        r_rr[s] <= '0;
      end
    end else if (w_last_ack && r_vic_rr && (WAYS > 1)) begin
      r_rr[r_lidx] <= r_rr[r_lidx] + 1'b1;
    end
  end

  // Fill stage: data and tag arrays (not reset)
  always_ff @(posedge clk) begin
    if (w_ack) begin
      r_data[r_lidx][r_victim][r_cnt] <= i_mem_data;
    end
    if (w_last_ack) begin
      r_tag[r_lidx][r_victim] <= r_ltag;
    end
  end

  assign o_hit      = (r_state == S_IDLE) && w_hit_any;
  assign o_rdata    = w_rdata;
  assign o_busy     = (r_state != S_IDLE);
  assign o_mem_req  = r_mem_req;
  assign o_mem_addr = r_mem_addr;

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (i_req && o_hit) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if (w_start_refill) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign o_hit_cnt  = r_hit_cnt;
  assign o_miss_cnt = r_miss_cnt;
`else
  assign o_hit_cnt  = '0;
  assign o_miss_cnt = '0;
`endif

endmodule

// File: tb/tb_icache_sa.sv
module tb_icache_sa;

  localparam int WAYS = 2;
  localparam int SETS = 4;
  localparam int LW   = 4;
  localparam logic [31:0] LMASK = 32'(LW * 4 - 1);

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_addr;
  logic        i_req;
  logic        o_hit;
  logic [31:0] o_rdata;
  logic        o_busy;
  logic        i_flush;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic [31:0] i_mem_data;
  logic        i_mem_vd;
  logic [31:0] o_hit_cnt;
  logic [31:0] o_miss_cnt;

  always #5 clk = ~clk;

  icache_sa #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_addr     (i_addr),
    .i_req      (i_req),
    .o_hit      (o_hit),
    .o_rdata    (o_rdata),
    .o_busy     (o_busy),
    .i_flush    (i_flush),
    .o_mem_req  (o_mem_req),
    .o_mem_addr (o_mem_addr),
    .i_mem_data (i_mem_data),
    .i_mem_vd   (i_mem_vd),
    .o_hit_cnt  (o_hit_cnt),
    .o_miss_cnt (o_miss_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check1(input string name, input logic got, input logic exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, got, exp);
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  // Reference model: each set holds up to WAYS line base addresses plus the
  // words supplied for them.
  bit          m_valid [SETS][WAYS];
  logic [31:0] m_line  [SETS][WAYS];
  logic [31:0] m_data  [SETS][WAYS][LW];
  int          m_rr    [SETS];
  logic [31:0] fill_buf[LW];

  function automatic int m_set(input logic [31:0] a);
    return int'((a / (LW * 4)) % SETS);
  endfunction

  function automatic int m_word(input logic [31:0] a);
    return int'((a / 4) % LW);
  endfunction

  function automatic int m_way(input logic [31:0] a);
    int s;
    s = m_set(a);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_line[s][w] == (a & ~LMASK)) return w;
    return -1;
  endfunction

  task automatic m_fill(input logic [31:0] a);
    int s;
    int v;
    s = m_set(a);
    v = -1;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!m_valid[s][w]) v = w;
    if (v < 0) begin
      v = m_rr[s];
      m_rr[s] = (m_rr[s] + 1) % WAYS;
    end
    m_valid[s][v] = 1'b1;
    m_line[s][v]  = a & ~LMASK;
    for (int k = 0; k < LW; k++) m_data[s][v][k] = fill_buf[k];
  endtask

  task automatic m_flush();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
  endtask

  task automatic m_reset();
    m_flush();
    for (int s = 0; s < SETS; s++) m_rr[s] = 0;
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Answer the refill word by word; gap idle cycles precede each word.
  task automatic serve(input logic [31:0] a, input int gap, input bit tbl, input int flush_at);
    logic [31:0] base;
    base = a & ~LMASK;
    for (int k = 0; k < LW; k++) begin
      for (int g = 0; g < gap; g++) begin
        check1("hold_req", o_mem_req, 1'b1);
        check32("hold_addr", o_mem_addr, base + 32'(4 * k));
        tick();
      end
      check1("mem_req", o_mem_req, 1'b1);
      check32("mem_addr", o_mem_addr, base + 32'(4 * k));
      fill_buf[k] = tbl ? (32'hA0 + 32'(k)) : memf(base + 32'(4 * k));
      i_mem_data  = fill_buf[k];
      i_mem_vd    = 1'b1;
      i_flush     = (k == flush_at);
      tick();
      i_mem_vd   = 1'b0;
      i_flush    = 1'b0;
      i_mem_data = '0;
    end
  endtask

  task automatic fetch(input logic [31:0] a, input int gap);
    int w;
    i_addr = a;
    i_req  = 1'b1;
    #1;
    w = m_way(a);
    check1("fetch_hit", o_hit, w >= 0);
    if (w >= 0) begin
      check32("fetch_data", o_rdata, m_data[m_set(a)][w][m_word(a)]);
      tick();
    end else begin
      tick();
      check1("miss_busy", o_busy, 1'b1);
      serve(a, gap, 1'b0, -1);
      m_fill(a);
      check1("refill_hit", o_hit, 1'b1);
      check32("refill_data", o_rdata, memf(a));
    end
    i_req = 1'b0;
    #1;
  endtask

  task automatic probe(input string name, input logic [31:0] a, input logic exp_hit);
    int w;
    i_req  = 1'b0;
    i_addr = a;
    #1;
    check1(name, o_hit, exp_hit);
    w = m_way(a);
    if (exp_hit && w >= 0) check32(name, o_rdata, m_data[m_set(a)][w][m_word(a)]);
    tick();
  endtask

  task automatic probe_model(input logic [31:0] a);
    int w;
    w = m_way(a);
    probe("rand_probe", a, w >= 0);
  endtask

  task automatic count_busy(input string name);
    int cnt;
    cnt = 0;
    while (o_busy && cnt < 20) begin
      cnt++;
      tick();
    end
    check32(name, 32'(cnt), 32'd4);
  endtask

  task automatic do_flush();
    i_req   = 1'b0;
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    count_busy("flush_cycles");
    m_flush();
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        hit;
    logic [31:0] data;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{32'h0000_0100, 1'b1, 32'h0000_00A0};
    tbl[1] = '{32'h0000_0104, 1'b1, 32'h0000_00A1};
    tbl[2] = '{32'h0000_0108, 1'b1, 32'h0000_00A2};
    tbl[3] = '{32'h0000_010C, 1'b1, 32'h0000_00A3};
    tbl[4] = '{32'h0000_0110, 1'b0, 32'h0000_0000};
    tbl[5] = '{32'h0000_0140, 1'b0, 32'h0000_0000};
    tbl[6] = '{32'h0000_0000, 1'b0, 32'h0000_0000};
    tbl[7] = '{32'h0000_030C, 1'b0, 32'h0000_0000};

    rst        = 1'b1;
    i_addr     = '0;
    i_req      = 1'b0;
    i_flush    = 1'b0;
    i_mem_data = '0;
    i_mem_vd   = 1'b0;
    m_reset();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check1("rst_hit", o_hit, 1'b0);
    check1("rst_busy", o_busy, 1'b0);
    check1("rst_mem_req", o_mem_req, 1'b0);
    check32("rst_mem_addr", o_mem_addr, 32'h0);
    check32("rst_hit_cnt", o_hit_cnt, 32'h0);
    check32("rst_miss_cnt", o_miss_cnt, 32'h0);

    // Cold miss at 0x108
    i_addr = 32'h108;
    i_req  = 1'b1;
    #1;
    check1("cold_hit_before", o_hit, 1'b0);
    tick();
    check1("cold_busy", o_busy, 1'b1);
    check1("cold_hit_refill", o_hit, 1'b0);
    serve(32'h108, 0, 1'b1, -1);
    m_fill(32'h108);
    check1("cold_hit", o_hit, 1'b1);
    check32("cold_rdata", o_rdata, 32'hA2);
    check1("cold_idle", o_busy, 1'b0);
`ifdef ICACHE_STATS_EN
    check32("cold_miss_cnt", o_miss_cnt, 32'd1);
`else
    check32("cold_miss_cnt", o_miss_cnt, 32'd0);
`endif
    i_req = 1'b0;
    #1;

    // Table-driven lookups over the freshly filled line
    for (int i = 0; i < 8; i++) begin
      i_addr = tbl[i].addr;
      #1;
      check1("tbl_hit", o_hit, tbl[i].hit);
      if (tbl[i].hit) check32("tbl_data", o_rdata, tbl[i].data);
      tick();
    end

    // Slow memory, set 1
    i_addr = 32'h314;
    i_req  = 1'b1;
    #1;
    check1("slow_miss", o_hit, 1'b0);
    tick();
    serve(32'h314, 3, 1'b0, -1);
    m_fill(32'h314);
    check1("slow_hit", o_hit, 1'b1);
    check32("slow_rdata", o_rdata, memf(32'h314));
    i_req = 1'b0;
    for (int k = 0; k < LW; k++) begin
      i_addr = 32'h310 + 32'(4 * k);
      #1;
      check32("slow_line", o_rdata, memf(32'h310 + 32'(4 * k)));
      tick();
    end

    // Conflict and round-robin replacement in set 0
    fetch(32'h140, 0);
    probe("conf_100_a", 32'h100, 1'b1);
    probe("conf_140_a", 32'h140, 1'b1);
    fetch(32'h180, 1);
    probe("conf_100_b", 32'h100, 1'b0);
    probe("conf_140_b", 32'h140, 1'b1);
    probe("conf_180_b", 32'h180, 1'b1);
    fetch(32'h1C0, 0);
    probe("conf_140_c", 32'h140, 1'b0);
    probe("conf_180_c", 32'h180, 1'b1);
    probe("conf_1c0_c", 32'h1C0, 1'b1);

    // Flush from IDLE
    do_flush();
    probe("flush_1c0", 32'h1C0, 1'b0);
    probe("flush_100", 32'h100, 1'b0);
    probe("flush_314", 32'h314, 1'b0);
    check32("flush_hit_cnt", o_hit_cnt, 32'h0);
    check32("flush_miss_cnt", o_miss_cnt, 32'h0);

    // Flush arriving during the 0x200 refill
    i_addr = 32'h200;
    i_req  = 1'b1;
    #1;
    tick();
    i_req = 1'b0;
    serve(32'h200, 0, 1'b0, 1);
    m_fill(32'h200);
    check1("fdr_mem_req", o_mem_req, 1'b0);
    check1("fdr_busy", o_busy, 1'b1);
    count_busy("fdr_flush_cycles");
    m_flush();
    probe("fdr_200", 32'h200, 1'b0);

    // Reset in the middle of a refill
    i_addr = 32'h200;
    i_req  = 1'b1;
    #1;
    tick();
    i_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_mem_data = memf(32'h200 + 32'(4 * k));
      i_mem_vd   = 1'b1;
      tick();
      i_mem_vd = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    m_reset();
    check1("mrst_mem_req", o_mem_req, 1'b0);
    check1("mrst_busy", o_busy, 1'b0);
    check1("mrst_hit", o_hit, 1'b0);
    i_addr = 32'h200;
    i_req  = 1'b1;
    #1;
    check1("mrst_miss", o_hit, 1'b0);
    tick();
    check32("mrst_refetch_base", o_mem_addr, 32'h200);
    serve(32'h200, 0, 1'b0, -1);
    m_fill(32'h200);
    check1("mrst_hit_after", o_hit, 1'b1);
    check32("mrst_rdata", o_rdata, memf(32'h200));
    i_req = 1'b0;
    #1;

    // Randomized traffic against the reference model
    for (int it = 0; it < 250; it++) begin
      int op;
      logic [31:0] a;
      op = int'($urandom_range(0, 19));
      a  = 32'($urandom_range(0, 127)) << 2;
      if (op == 0) do_flush();
      else if (op < 5) probe_model(a);
      else fetch(a, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
